// File: rtl/sprite_dma.sv
// sprite_dma: bus-mastering page-copy DMA for the 2A03 CPU complex.
// A write to TRIGGER_ADDR halts the CPU and copies LEN bytes from {page,idx} to dest.
module sprite_dma #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR    = 16'h2004,
   parameter int unsigned LEN          = 256,
   parameter bit          DEST_INCR    = 1'b0
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_data_in,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data_out,
   output logic        bus_rw,
   output logic        halt,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      state_q;
   logic        parity_q;
   logic [7:0]  page_q;
   logic [8:0]  idx_q;
   logic [8:0]  idx_d;
   logic [15:0] dest_q;
   logic [15:0] dest_d;
   logic [7:0]  data_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        rw_q;
   logic        halt_q;
   logic        busy_q;
   logic        trig;
   logic        last;

   assign trig   = !cpu_rw && (cpu_addr == TRIGGER_ADDR);
   assign idx_d  = idx_q + 9'd1;
   assign dest_d = DEST_INCR ? dest_q + 16'd1 : dest_q;
   assign last   = (idx_q == 9'(LEN - 1));

   // Outputs are registered: each transition loads the bus values of the state being entered.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q  <= S_IDLE;
         parity_q <= 1'b0;
         page_q   <= 8'h00;
         idx_q    <= 9'd0;
         dest_q   <= 16'h0000;
         data_q   <= 8'h00;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         rw_q     <= 1'b1;
         halt_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         parity_q <= ~parity_q;
         unique case (state_q)
            S_IDLE: begin
               if (trig) begin
                  state_q <= S_HALT;
                  page_q  <= cpu_data_out;
                  idx_q   <= 9'd0;
                  dest_q  <= DEST_ADDR;
                  addr_q  <= {cpu_data_out, 8'h00};
                  wdata_q <= 8'h00;
                  rw_q    <= 1'b1;
                  halt_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_HALT: begin
               // parity_q=0 now means the next cycle is a put cycle
               if (!parity_q) begin
                  state_q <= S_ALIGN;
                  addr_q  <= {page_q, 8'h00};
               end else begin
                  state_q <= S_READ;
                  addr_q  <= {page_q, idx_q[7:0]};
               end
               rw_q <= 1'b1;
            end
            S_ALIGN: begin
               state_q <= S_READ;
               addr_q  <= {page_q, idx_q[7:0]};
               rw_q    <= 1'b1;
            end
            S_READ: begin
               state_q <= S_WRITE;
               data_q  <= bus_data_in;
               addr_q  <= dest_q;
               wdata_q <= bus_data_in;
               rw_q    <= 1'b0;
            end
            S_WRITE: begin
               idx_q   <= idx_d;
               dest_q  <= dest_d;
               wdata_q <= 8'h00;
               rw_q    <= 1'b1;
               if (last) begin
                  state_q <= S_IDLE;
                  addr_q  <= 16'h0000;
                  halt_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_READ;
                  addr_q  <= {page_q, idx_d[7:0]};
               end
            end
            default: begin
               state_q <= S_IDLE;
               addr_q  <= 16'h0000;
               wdata_q <= 8'h00;
               rw_q    <= 1'b1;
               halt_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_addr     = addr_q;
   assign bus_data_out = wdata_q;
   assign bus_rw       = rw_q;
   assign halt         = halt_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: default 256-byte copy, incrementing
// wrap-around destination, single-byte copy, false triggers and mid-copy reset.
module tb_sprite_dma;

   logic        clock = 1'b0;
   logic        nreset = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data_out = 8'h00;
   logic [2:0]  crw = 3'b111;

   logic [2:0]  halt_w;
   logic [2:0]  busy_w;
   logic [2:0]  rw_w;
   logic [15:0] addr_w [3];
   logic [7:0]  dout_w [3];
   logic [7:0]  din_w  [3];

   logic [7:0]  mem [65536];
   logic        tp;

   logic [15:0] wa0[$];
   logic [7:0]  wd0[$];
   logic [15:0] wa1[$];
   logic [7:0]  wd1[$];
   logic [15:0] wa2[$];
   logic [7:0]  wd2[$];

   int n_assert = 0;
   int n_fail = 0;
   int perr = 0;

   always #5 clock = ~clock;

   assign din_w[0] = mem[addr_w[0]];
   assign din_w[1] = mem[addr_w[1]];
   assign din_w[2] = mem[addr_w[2]];

   sprite_dma u0 (
      .clock(clock), .nreset(nreset), .cpu_addr(cpu_addr),
      .cpu_data_out(cpu_data_out), .cpu_rw(crw[0]), .bus_data_in(din_w[0]),
      .bus_addr(addr_w[0]), .bus_data_out(dout_w[0]), .bus_rw(rw_w[0]),
      .halt(halt_w[0]), .busy(busy_w[0])
   );

   sprite_dma #(.DEST_ADDR(16'hFFFE), .LEN(4), .DEST_INCR(1'b1)) u1 (
      .clock(clock), .nreset(nreset), .cpu_addr(cpu_addr),
      .cpu_data_out(cpu_data_out), .cpu_rw(crw[1]), .bus_data_in(din_w[1]),
      .bus_addr(addr_w[1]), .bus_data_out(dout_w[1]), .bus_rw(rw_w[1]),
      .halt(halt_w[1]), .busy(busy_w[1])
   );

   sprite_dma #(.LEN(1)) u2 (
      .clock(clock), .nreset(nreset), .cpu_addr(cpu_addr),
      .cpu_data_out(cpu_data_out), .cpu_rw(crw[2]), .bus_data_in(din_w[2]),
      .bus_addr(addr_w[2]), .bus_data_out(dout_w[2]), .bus_rw(rw_w[2]),
      .halt(halt_w[2]), .busy(busy_w[2])
   );

   // Reference get/put parity: 0 out of reset, toggling every clock.
   always @(posedge clock or negedge nreset) begin
      if (!nreset) tp <= 1'b0;
      else tp <= ~tp;
   end

   always @(negedge clock) begin
      if (halt_w[0] && !rw_w[0]) begin
         wa0.push_back(addr_w[0]);
         wd0.push_back(dout_w[0]);
         if (!tp) perr++;
      end
      if (halt_w[1] && !rw_w[1]) begin
         wa1.push_back(addr_w[1]);
         wd1.push_back(dout_w[1]);
         if (!tp) perr++;
      end
      if (halt_w[2] && !rw_w[2]) begin
         wa2.push_back(addr_w[2]);
         wd2.push_back(dout_w[2]);
         if (!tp) perr++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive one CPU cycle on DUT k, sampled at the end of a cycle of parity want_tp.
   task automatic cpu_cyc(input int k, input logic [15:0] a, input logic [7:0] d,
                          input logic rw, input logic want_tp);
      while (tp != want_tp) step();
      cpu_addr = a;
      cpu_data_out = d;
      crw[k] = rw;
      step();
      crw = 3'b111;
      cpu_addr = 16'h0000;
      cpu_data_out = 8'h00;
   endtask

   task automatic count_halt(input int k, output int n);
      n = 0;
      while (halt_w[k] && n < 2000) begin
         n++;
         step();
      end
   endtask

   task automatic clear_q();
      wa0.delete(); wd0.delete();
      wa1.delete(); wd1.delete();
      wa2.delete(); wd2.delete();
      perr = 0;
   endtask

   initial begin
      int n;
      int bad;
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
      mem[16'h0300] = 8'h11;
      mem[16'h0301] = 8'h22;
      mem[16'h0302] = 8'h33;
      mem[16'h0303] = 8'h44;
      mem[16'hC000] = 8'hA5;

      #22 nreset = 1'b1;
      #1;
      check("rst_halt", 32'(halt_w), 0);
      check("rst_busy", 32'(busy_w), 0);
      check("rst_rw", 32'(rw_w), 32'h7);
      check("rst_addr", 32'(addr_w[0]), 0);
      check("rst_dout", 32'(dout_w[0]), 0);
      step();

      // Trigger in a parity-0 cycle: no ALIGN
      clear_q();
      cpu_cyc(0, 16'h4014, 8'h02, 1'b0, 1'b0);
      count_halt(0, n);
      check("t1_halt_cycles", n, 513);
      check("t1_nwrites", wa0.size(), 256);
      bad = 0;
      for (int i = 0; i < wa0.size(); i++)
         if (wa0[i] !== 16'h2004 || wd0[i] !== 8'(i)) bad++;
      check("t1_stream_bad", bad, 0);
      check("t1_parity_err", perr, 0);
      check("t1_busy_after", busy_w[0], 0);
      check("t1_addr_after", addr_w[0], 0);
      check("t1_rw_after", rw_w[0], 1);

      // Trigger one cycle later: ALIGN inserted
      clear_q();
      cpu_cyc(0, 16'h4014, 8'h02, 1'b0, 1'b1);
      count_halt(0, n);
      check("t2_halt_cycles", n, 514);
      bad = 0;
      for (int i = 0; i < wa0.size(); i++)
         if (wa0[i] !== 16'h2004 || wd0[i] !== 8'(i)) bad++;
      check("t2_nwrites", wa0.size(), 256);
      check("t2_stream_bad", bad, 0);
      check("t2_parity_err", perr, 0);

      // False triggers
      clear_q();
      cpu_cyc(0, 16'h4014, 8'h02, 1'b1, 1'b0);
      check("t3_rd_halt", halt_w[0], 0);
      check("t3_rd_busy", busy_w[0], 0);
      cpu_cyc(0, 16'h4015, 8'h02, 1'b0, 1'b0);
      check("t3_wr_halt", halt_w[0], 0);
      check("t3_wr_busy", busy_w[0], 0);
      step();
      step();
      check("t3_nwrites", wa0.size(), 0);

      // Incrementing destination with 16-bit wrap
      clear_q();
      cpu_cyc(1, 16'h4014, 8'h03, 1'b0, 1'b0);
      count_halt(1, n);
      check("t4_halt_cycles", n, 9);
      check("t4_nwrites", wa1.size(), 4);
      if (wa1.size() == 4) begin
         check("t4_a0", wa1[0], 32'hFFFE);
         check("t4_a1", wa1[1], 32'hFFFF);
         check("t4_a2", wa1[2], 32'h0000);
         check("t4_a3", wa1[3], 32'h0001);
         check("t4_d0", wd1[0], 32'h11);
         check("t4_d3", wd1[3], 32'h44);
      end
      check("t4_u0_idle", busy_w[0], 0);

      // Reset in the middle of a transfer
      clear_q();
      cpu_cyc(0, 16'h4014, 8'h02, 1'b0, 1'b0);
      n = 0;
      while (wa0.size() < 100 && n < 1000) begin
         n++;
         step();
      end
      check("t5_reached_100", wa0.size(), 100);
      #2 nreset = 1'b0;
      #1;
      check("t5_rst_halt", halt_w[0], 0);
      check("t5_rst_busy", busy_w[0], 0);
      #10 nreset = 1'b1;
      step();
      clear_q();
      cpu_cyc(0, 16'h4014, 8'h02, 1'b0, 1'b0);
      count_halt(0, n);
      check("t5_halt_cycles", n, 513);
      check("t5_nwrites", wa0.size(), 256);
      if (wa0.size() > 0) begin
         check("t5_first_addr", wa0[0], 32'h2004);
         check("t5_first_data", wd0[0], 32'h00);
      end

      // Single-byte transfer, both trigger parities
      clear_q();
      cpu_cyc(2, 16'h4014, 8'hC0, 1'b0, 1'b0);
      count_halt(2, n);
      check("t6_halt_p0", n, 3);
      cpu_cyc(2, 16'h4014, 8'hC0, 1'b0, 1'b1);
      count_halt(2, n);
      check("t6_halt_p1", n, 4);
      check("t6_nwrites", wa2.size(), 2);
      bad = 0;
      for (int i = 0; i < wa2.size(); i++)
         if (wa2[i] !== 16'h2004 || wd2[i] !== 8'hA5) bad++;
      check("t6_stream_bad", bad, 0);
      check("t6_parity_err", perr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
